// File: rtl/lif_pkg.sv
// Shared defaults and FSM encoding for the LIF neuron core and its input spike queue.
package lif_pkg;

  localparam int          LIF_N          = 32;
  localparam int          LIF_WW         = 8;
  localparam int          LIF_VW         = 16;
  localparam logic [15:0] LIF_THRESH     = 16'h0100;
  localparam int          LIF_LEAK_SHIFT = 4;
  localparam int          IDX_W          = 5;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    INTEGRATE
  } state_t;

endpackage

// File: rtl/spike_fifo.sv
// Circular input spike queue: first-word fall-through head, registered empty/full flags.
module spike_fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         reset_input_queue,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  logic [B-1:0] mem [2**W];
  logic [W-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic         push_en, pop_en;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop_en     = rd && !empty;
    push_en    = wr && (!full || pop_en);
    wr_ptr_nxt = wr_ptr + 1'b1;
    rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // NOTE: queue storage is not reset; the pointers and flags alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_en && !reset_input_queue) mem[wr_ptr] <= w_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i || reset_input_queue) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr_nxt;
      if (pop_en)  rd_ptr <= rd_ptr_nxt;
      case ({push_en, pop_en})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wr_ptr_nxt == rd_ptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rd_ptr_nxt == wr_ptr);
        end
        default: ;
      endcase
    end
  end

  assign r_data = mem[rd_ptr];

endmodule

// File: rtl/lif_n_core.sv
// LIF neuron array: pops presynaptic spike indices and integrates one postsynaptic neuron per cycle.
module lif_n_core
  import lif_pkg::*;
#(
  parameter int          B          = 8,
  parameter int          W          = 4,
  parameter int          N          = LIF_N,
  parameter int          WW         = LIF_WW,
  parameter int          VW         = LIF_VW,
  parameter logic [15:0] THRESH     = LIF_THRESH,
  parameter int          LEAK_SHIFT = LIF_LEAK_SHIFT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reset_input_queue,
  input  logic             en_core,
  input  logic             wr_input_queue,
  input  logic [B-1:0]     w_data_input_queue,
  input  logic             rd_input_queue,
  output logic [B-1:0]     r_data_input_queue,
  output logic             empty_input_queue,
  output logic             full_input_queue,
  output logic             spike_o_valid,
  output logic [IDX_W-1:0] spike_o_idx,
  output logic             busy_o
);

  logic [WW-1:0] weights_mem [N][N];
  logic [VW-1:0] membrane_potential_memory [N];

  state_t           current_state, next_state;
  logic             core_pop;
  logic [IDX_W-1:0] presyn_idx, postsyn_idx;

  spike_fifo #(.B(B), .W(W)) u_input_queue (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .reset_input_queue (reset_input_queue),
    .wr                (wr_input_queue),
    .w_data            (w_data_input_queue),
    .rd                (core_pop || rd_input_queue),
    .r_data            (r_data_input_queue),
    .empty             (empty_input_queue),
    .full              (full_input_queue)
  );

  // Only the low bits of a queued word name a neuron.
  logic unused_head_bits;
  assign unused_head_bits = ^r_data_input_queue[B-1:IDX_W];

  logic [VW-1:0] v_cur, v_leaked, t_sat;
  logic [WW-1:0] w_cur;
  logic [VW:0]   t_wide;
  logic          fire;

  always_comb begin
    v_cur    = membrane_potential_memory[postsyn_idx];
    w_cur    = weights_mem[presyn_idx][postsyn_idx];
    v_leaked = v_cur - (v_cur >> LEAK_SHIFT);
    t_wide   = {1'b0, v_leaked} + {{(VW + 1 - WW){1'b0}}, w_cur};
    t_sat    = t_wide[VW] ? '1 : t_wide[VW-1:0];
    fire     = (t_sat >= THRESH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) current_state <= IDLE;
    else        current_state <= next_state;
  end

  always_comb begin
    next_state = current_state;
    core_pop   = 1'b0;
    case (current_state)
      IDLE:      if (en_core && !empty_input_queue) next_state = FETCH;
      // An external drain can empty the queue between IDLE and FETCH; fall back instead of latching a stale head.
      FETCH: begin
        core_pop   = !empty_input_queue;
        next_state = empty_input_queue ? IDLE : INTEGRATE;
      end
      INTEGRATE: if (postsyn_idx == IDX_W'(N - 1)) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      presyn_idx    <= '0;
      postsyn_idx   <= '0;
      spike_o_valid <= 1'b0;
      spike_o_idx   <= '0;
    end else begin
      spike_o_valid <= 1'b0;
      case (current_state)
        FETCH: begin
          presyn_idx  <= r_data_input_queue[IDX_W-1:0];
          postsyn_idx <= '0;
        end
        INTEGRATE: begin
          postsyn_idx <= postsyn_idx + 1'b1;
          if (fire) begin
            spike_o_valid <= 1'b1;
            spike_o_idx   <= postsyn_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) membrane_potential_memory[i] <= '0;
    end else if (current_state == INTEGRATE) begin
      membrane_potential_memory[postsyn_idx] <= fire ? '0 : t_sat;
    end
  end

  assign busy_o = (current_state != IDLE);

endmodule

// File: tb/tb_lif_n_core.sv
// Directed bench for lif_n_core: integration, leak, firing, queue flags/order and queue clear.
module tb_lif_n_core;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       reset_input_queue;
  logic       en_core;
  logic       wr_input_queue;
  logic [7:0] w_data_input_queue;
  logic       rd_input_queue;
  logic [7:0] r_data_input_queue;
  logic       empty_input_queue;
  logic       full_input_queue;
  logic       spike_o_valid;
  logic [4:0] spike_o_idx;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  lif_n_core dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .reset_input_queue  (reset_input_queue),
    .en_core            (en_core),
    .wr_input_queue     (wr_input_queue),
    .w_data_input_queue (w_data_input_queue),
    .rd_input_queue     (rd_input_queue),
    .r_data_input_queue (r_data_input_queue),
    .empty_input_queue  (empty_input_queue),
    .full_input_queue   (full_input_queue),
    .spike_o_valid      (spike_o_valid),
    .spike_o_idx        (spike_o_idx),
    .busy_o             (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activity monitor, sampled on the falling edge.
  int         spike_cnt = 0;
  int         busy_cyc  = 0;
  int         idle_wait = 0;
  int         run       = 0;
  int         max_run   = 0;
  logic [4:0] last_idx  = '0;

  always @(negedge clk_i) begin
    if (busy_o) busy_cyc++;
    if (!busy_o && !empty_input_queue && en_core) idle_wait++;
    if (spike_o_valid) begin
      spike_cnt++;
      last_idx = spike_o_idx;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  function automatic logic [15:0] v_of(input int k);
    return dut.membrane_potential_memory[k];
  endfunction

  task automatic push(input logic [7:0] d);
    wr_input_queue     = 1'b1;
    w_data_input_queue = d;
    @(negedge clk_i);
    wr_input_queue     = 1'b0;
  endtask

  task automatic pop();
    rd_input_queue = 1'b1;
    @(negedge clk_i);
    rd_input_queue = 1'b0;
  endtask

  task automatic core_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(empty_input_queue && !busy_o) && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 400), 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 400), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          b_busy, b_spk, b_idle;
    logic [15:0] acc;

    rst_i              = 1'b0;
    reset_input_queue  = 1'b0;
    en_core            = 1'b0;
    wr_input_queue     = 1'b0;
    w_data_input_queue = '0;
    rd_input_queue     = 1'b0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        dut.weights_mem[i][j] = (i == j) ? 8'h10 : 8'h05;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_empty", 32'(empty_input_queue), 32'd1);
    check("rst_full", 32'(full_input_queue), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_spike_valid", 32'(spike_o_valid), 32'd0);
    check("rst_spike_idx", 32'(spike_o_idx), 32'd0);
    acc = '0;
    for (int k = 0; k < 32; k++) acc |= v_of(k);
    check("rst_v_all_zero", 32'(acc), 32'd0);
    rst_i = 1'b1;

    // One spike from neuron 0
    en_core = 1'b1;
    b_busy = busy_cyc; b_spk = spike_cnt; b_idle = idle_wait;
    push(8'd0);
    wait_done("single");
    check("single_v0", 32'(v_of(0)), 32'h10);
    check("single_v5", 32'(v_of(5)), 32'h05);
    check("single_v31", 32'(v_of(31)), 32'h05);
    check("single_busy_cycles", 32'(busy_cyc - b_busy), 32'd33);
    check("single_no_spike", 32'(spike_cnt - b_spk), 32'd0);
    check("single_idle_wait", 32'(idle_wait - b_idle), 32'd1);

    // Second spike from neuron 0: leak then integrate
    push(8'd0);
    wait_done("double");
    check("double_v0", 32'(v_of(0)), 32'h1F);
    check("double_v1", 32'(v_of(1)), 32'h0A);
    check("double_v31", 32'(v_of(31)), 32'h0A);

    // Back-to-back spikes 1 then 2: 33 busy cycles each, one IDLE cycle between
    b_busy = busy_cyc; b_idle = idle_wait;
    push(8'd1);
    push(8'd2);
    wait_done("b2b");
    check("b2b_busy_cycles", 32'(busy_cyc - b_busy), 32'd66);
    check("b2b_idle_wait", 32'(idle_wait - b_idle), 32'd2);
    check("b2b_v0", 32'(v_of(0)), 32'h26);
    check("b2b_v1", 32'(v_of(1)), 32'h1E);
    check("b2b_v2", 32'(v_of(2)), 32'h1F);

    // Threshold crossing on the second spike of neuron 3
    core_reset();
    dut.weights_mem[3][7] = 8'hFF;
    b_spk = spike_cnt; max_run = 0;
    push(8'd3);
    push(8'd3);
    wait_done("fire");
    check("fire_count", 32'(spike_cnt - b_spk), 32'd1);
    check("fire_idx", 32'(last_idx), 32'd7);
    check("fire_pulse_width", 32'(max_run), 32'd1);
    check("fire_v7_reset", 32'(v_of(7)), 32'h0);
    check("fire_v3", 32'(v_of(3)), 32'h1F);
    check("fire_v0", 32'(v_of(0)), 32'h0A);
    dut.weights_mem[3][7] = 8'h05;

    // en_core dropped mid-spike: current spike completes, next stays queued
    core_reset();
    push(8'd0);
    push(8'd0);
    repeat (3) @(negedge clk_i);
    en_core = 1'b0;
    wait_idle("en_drop");
    repeat (3) @(negedge clk_i);
    check("en_drop_busy", 32'(busy_o), 32'd0);
    check("en_drop_v0", 32'(v_of(0)), 32'h10);
    check("en_drop_v7", 32'(v_of(7)), 32'h05);
    check("en_drop_not_empty", 32'(empty_input_queue), 32'd0);
    check("en_drop_head", 32'(r_data_input_queue), 32'h00);

    // Queue clear overrides a same-cycle push; membrane state untouched
    reset_input_queue  = 1'b1;
    wr_input_queue     = 1'b1;
    w_data_input_queue = 8'h09;
    @(negedge clk_i);
    reset_input_queue  = 1'b0;
    wr_input_queue     = 1'b0;
    check("qclr_empty", 32'(empty_input_queue), 32'd1);
    check("qclr_full", 32'(full_input_queue), 32'd0);
    check("qclr_v0_kept", 32'(v_of(0)), 32'h10);

    // Fill the queue, overflow, push+pop while full, drain in order
    for (int i = 0; i < 15; i++) push(8'(8'h20 + i));
    check("fill15_not_full", 32'(full_input_queue), 32'd0);
    push(8'h2F);
    check("fill16_full", 32'(full_input_queue), 32'd1);
    check("fill16_head", 32'(r_data_input_queue), 32'h20);
    push(8'h77);
    check("overflow_still_full", 32'(full_input_queue), 32'd1);
    wr_input_queue     = 1'b1;
    w_data_input_queue = 8'h55;
    rd_input_queue     = 1'b1;
    @(negedge clk_i);
    wr_input_queue     = 1'b0;
    rd_input_queue     = 1'b0;
    check("pushpop_full", 32'(full_input_queue), 32'd1);
    check("pushpop_head", 32'(r_data_input_queue), 32'h21);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(r_data_input_queue),
            (i < 15) ? 32'(8'h21 + i) : 32'h55);
      pop();
    end
    check("drain_empty", 32'(empty_input_queue), 32'd1);
    check("drain_not_full", 32'(full_input_queue), 32'd0);
    pop();
    check("underflow_empty", 32'(empty_input_queue), 32'd1);
    push(8'h3C);
    check("after_underflow_head", 32'(r_data_input_queue), 32'h3C);
    check("after_underflow_not_empty", 32'(empty_input_queue), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
